// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side next-PC selection and control FSM for the single-cycle core.
// Ports: clk/a_rstn (async active-low reset); i_pc current PC; i_stall, i_halt, i_resume control;
//   i_jump/i_jump_target and i_branch_taken/i_branch_target redirects; o_next_pc and o_instr_valid
//   (combinational); o_halted, o_trap, o_trap_pc, o_instret (registered).
// Macro PC_SEQ_TRAP_EN: when defined, a bad redirect target traps to TRAP_VECTOR; otherwise it is sanitized.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned IMEM_BYTES   = 4096
) (
  input  logic        clk,
  input  logic        a_rstn,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_halt,
  input  logic        i_resume,
  output logic [31:0] o_next_pc,
  output logic        o_instr_valid,
  output logic        o_halted,
  output logic        o_trap,
  output logic [31:0] o_trap_pc,
  output logic [31:0] o_instret
);
  localparam logic [31:0] MASK = 32'(IMEM_BYTES - 1);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
`ifdef PC_SEQ_TRAP_EN
  localparam logic [1:0] TRAP = 2'd3;
  logic        trap_set;
  logic        trap_q;
  logic [31:0] trap_pc_q;
`endif
  logic [1:0]  state_q, state_d;
  logic [31:0] instret_q;
  logic [31:0] tgt;
  logic        redirect, bad;
  // Jump outranks branch when both resolve in the same cycle.
  assign redirect = i_jump | i_branch_taken;
  assign tgt      = i_jump ? i_jump_target : i_branch_target;
  assign bad      = (tgt[1:0] != 2'b00) || (tgt > MASK);
  always_comb begin
    state_d       = state_q;
    o_next_pc     = i_pc;
    o_instr_valid = 1'b0;
`ifdef PC_SEQ_TRAP_EN
    trap_set      = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        o_next_pc = RESET_VECTOR;
        state_d   = RUN;
      end
      RUN: begin
        if (i_halt) state_d = HALT;
        else if (!i_stall) begin
          o_instr_valid = 1'b1;
          if (!redirect) o_next_pc = (i_pc + 32'd4) & MASK;
          else if (!bad) o_next_pc = tgt;
`ifdef PC_SEQ_TRAP_EN
          else begin
            o_next_pc = TRAP_VECTOR;
            trap_set  = 1'b1;
            state_d   = TRAP;
          end
`else
          else o_next_pc = tgt & ~32'h3 & MASK;
`endif
        end
      end
      HALT: state_d = i_resume ? RUN : HALT;
`ifdef PC_SEQ_TRAP_EN
      // Bubble cycle while i_pc settles on the trap vector; halt still wins.
      TRAP: state_d = i_halt ? HALT : RUN;
`endif
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      state_q   <= BOOT;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + {31'd0, o_instr_valid};
    end
  end
`ifdef PC_SEQ_TRAP_EN
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      trap_q    <= 1'b0;
      trap_pc_q <= 32'd0;
    end else if (trap_set) begin
      trap_q    <= 1'b1;
      trap_pc_q <= i_pc;
    end
  end
  assign o_trap    = trap_q;
  assign o_trap_pc = trap_pc_q;
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign o_trap    = 1'b0;
  assign o_trap_pc = 32'd0;
`endif
  assign o_halted  = (state_q == HALT);
  assign o_instret = instret_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer against a behavioural fetch model.
module tb_pc_sequencer;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;
  localparam int unsigned IMEM = 4096;
  logic        clk = 1'b0;
  logic        a_rstn = 1'b0;
  logic [31:0] i_pc = 32'd0;
  logic        i_stall = 1'b0, i_branch_taken = 1'b0, i_jump = 1'b0, i_halt = 1'b0, i_resume = 1'b0;
  logic [31:0] i_branch_target = 32'd0, i_jump_target = 32'd0;
  logic [31:0] o_next_pc, o_trap_pc, o_instret;
  logic        o_instr_valid, o_halted, o_trap;
  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .IMEM_BYTES(IMEM)) dut (
    .clk(clk), .a_rstn(a_rstn), .i_pc(i_pc), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump(i_jump), .i_jump_target(i_jump_target), .i_halt(i_halt), .i_resume(i_resume),
    .o_next_pc(o_next_pc), .o_instr_valid(o_instr_valid), .o_halted(o_halted),
    .o_trap(o_trap), .o_trap_pc(o_trap_pc), .o_instret(o_instret)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] np;
    logic        v;
    logic        h;
    logic        t;
    logic [31:0] tpc;
    logic [31:0] ir;
  } exp_t;
  exp_t q[$];
  event chk_ev;
  int total = 0;
  int bad = 0;
  // Model of the fetch side: the PC register plus the sequencer's observable behaviour.
  logic [31:0] pc;
  logic        m_boot, m_halt, m_bub, m_trap;
  logic [31:0] m_tpc, m_ir;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", name, got, want, $time);
    end
  endtask
  always @(chk_ev) begin
    exp_t e;
    #2;
    if (q.size() == 0) chk("queue_underflow", 32'd0, 32'd1);
    else begin
      e = q.pop_front();
      chk("next_pc", o_next_pc, e.np);
      chk("instr_valid", {31'd0, o_instr_valid}, {31'd0, e.v});
      chk("halted", {31'd0, o_halted}, {31'd0, e.h});
      chk("trap", {31'd0, o_trap}, {31'd0, e.t});
      chk("trap_pc", o_trap_pc, e.tpc);
      chk("instret", o_instret, e.ir);
    end
  end
  task automatic model_reset;
    pc = RV; m_boot = 1'b1; m_halt = 1'b0; m_bub = 1'b0; m_trap = 1'b0; m_tpc = 32'd0; m_ir = 32'd0;
  endtask
  // Called at a falling edge: drive, predict, hand expectation to the monitor, advance model, wait one cycle.
  task automatic cycle(input logic st, input logic hl, input logic rs, input logic jp,
                       input logic [31:0] jt, input logic br, input logic [31:0] bt);
    exp_t e;
    logic [31:0] t;
    i_pc = pc; i_stall = st; i_halt = hl; i_resume = rs;
    i_jump = jp; i_jump_target = jt; i_branch_taken = br; i_branch_target = bt;
    e.h = m_halt; e.t = m_trap; e.tpc = m_tpc; e.ir = m_ir;
    e.np = pc; e.v = 1'b0;
    if (m_boot) begin
      e.np = RV; m_boot = 1'b0;
    end else if (m_halt) begin
      if (rs) m_halt = 1'b0;
    end else if (hl) begin
      m_halt = 1'b1; m_bub = 1'b0;
    end else if (m_bub) m_bub = 1'b0;
    else if (!st) begin
      e.v = 1'b1;
      if (jp || br) begin
        t = jp ? jt : bt;
        if (t % 4 != 0 || t >= IMEM) begin
`ifdef PC_SEQ_TRAP_EN
          e.np = TV; m_trap = 1'b1; m_tpc = pc; m_bub = 1'b1;
`else
          e.np = (t - t % 4) % IMEM;
`endif
        end else e.np = t;
      end else e.np = (pc + 4) % IMEM;
    end
    q.push_back(e);
    -> chk_ev;
    pc = e.np;
    m_ir = m_ir + (e.v ? 32'd1 : 32'd0);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  // Assert reset between edges, check outputs react immediately, release on a falling edge.
  task automatic do_reset;
    #4 a_rstn = 1'b0;
    #1;
    chk("rst_next_pc", o_next_pc, RV);
    chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_trap", {31'd0, o_trap}, 32'd0);
    chk("rst_trap_pc", o_trap_pc, 32'd0);
    chk("rst_instret", o_instret, 32'd0);
    model_reset();
    @(negedge clk);
    a_rstn = 1'b1;
  endtask
  function automatic logic [31:0] rnd_target;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0, 1: return r & (IMEM - 1) & ~32'h3;
      2: return (r & (IMEM - 1)) | 32'h1;
      default: return r | IMEM;
    endcase
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
    $fatal(1);
  end
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    idle(4);
    chk("boot_instret", o_instret, 32'd3);
    chk("boot_pc", pc, 32'd12);
    pc = 32'd4092;
    idle(2);
    pc = 32'd8;
    cycle(0, 0, 0, 1, 32'h40, 1, 32'h80);
    pc = 32'h20;
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    pc = 32'h10;
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    pc = 32'h30;
    cycle(0, 0, 0, 1, 32'h102, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, 1, 32'h2000);
    idle(1);
    cycle(0, 0, 0, 1, 32'h7, 0, 0);
    do_reset();
    idle(3);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    do_reset();
    idle(3);
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, rnd_target(), $urandom_range(0, 4) == 0, rnd_target());
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
